alu_issue_unit: RTL and testbench

Upstream issue stage for the ALU datapath and its op decoder.
- Buffers incoming ALU commands (3-bit op plus two operands) in a small FIFO.
- Presents one command at a time on stable alu_op/alu_a/alu_b for a fixed ALU latency, then captures alu_result.
- Returns each result with its op on a valid/ready output channel.

---
 rtl/alu_issue_unit.sv | 138 +++++++++++++
 tb/tb_alu_issue_unit.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_unit.sv
// Issue stage for the ALU: queues commands, holds operands stable for the ALU
// latency, captures the result and returns it on a valid/ready channel.
module alu_issue_unit #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [2:0]                 cmd_op,
    input  logic [WIDTH-1:0]           cmd_a,
    input  logic [WIDTH-1:0]           cmd_b,
    output logic [2:0]                 alu_op,
    output logic [WIDTH-1:0]           alu_a,
    output logic [WIDTH-1:0]           alu_b,
    input  logic [WIDTH-1:0]           alu_result,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [WIDTH-1:0]           res_data,
    output logic [2:0]                 res_op,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [15:0]                op_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int LW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, OUT} state_t;

    typedef struct packed {
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } cmd_t;

    cmd_t            mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    state_t          state_q;
    logic [LW-1:0]   lat_q;
    logic [2:0]      alu_op_q;
    logic [WIDTH-1:0] alu_a_q, alu_b_q;
    logic            res_valid_q;
    logic [WIDTH-1:0] res_data_q;
    logic [2:0]      res_op_q;
    logic [15:0]     op_count_q, op_count_d;

    logic push, pop;
    cmd_t head;

    // Ready depends only on registered occupancy, never on res_ready.
    assign cmd_ready  = (count_q < CW'(DEPTH));
    assign push       = cmd_valid && cmd_ready;
    assign pop        = (state_q == IDLE) && (count_q != '0);
    assign head       = mem_q[rd_ptr_q];
    assign op_count_d = op_count_q + 16'd1;

    // NOTE: storage array is deliberately not reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{op: cmd_op, a: cmd_a, b: cmd_b};
    end

    // NOTE: all sequential state uses non-blocking assignment so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lat_q       <= '0;
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_op_q    <= '0;
            op_count_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        alu_op_q <= head.op;
                        alu_a_q  <= head.a;
                        alu_b_q  <= head.b;
                        lat_q    <= LW'(ALU_LAT - 1);
                        state_q  <= EXEC;
                    end
                end
                EXEC: begin
                    if (lat_q == '0) begin
                        res_data_q  <= alu_result;
                        res_op_q    <= alu_op_q;
                        res_valid_q <= 1'b1;
                        state_q     <= OUT;
                    end else begin
                        lat_q <= lat_q - LW'(1);
                    end
                end
                OUT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        op_count_q  <= op_count_d;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign alu_op     = alu_op_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_op     = res_op_q;
    assign op_count   = op_count_q;
    assign fifo_count = count_q;
    assign busy       = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: a scoreboard-checked ALU_LAT=1 instance with an A+B
// ALU, plus an ALU_LAT=3 instance whose ALU output changes every cycle.
module tb_alu_issue_unit;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [31:0] tick = 32'd0;
    always @(posedge clk) tick <= tick + 32'd1;

    // Instance A: ALU_LAT=1, ALU = A+B
    logic             cmd_valid, cmd_ready, res_valid, res_ready, busy;
    logic [2:0]       cmd_op, alu_op, res_op;
    logic [WIDTH-1:0] cmd_a, cmd_b, alu_a, alu_b, alu_result, res_data;
    logic [2:0]       fifo_count;
    logic [15:0]      op_count;

    assign alu_result = alu_a + alu_b;

    alu_issue_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ALU_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_op(res_op),
        .busy(busy), .fifo_count(fifo_count), .op_count(op_count)
    );

    // Instance B: ALU_LAT=3, ALU output drifts with the cycle counter
    logic             cmd_valid3, cmd_ready3, res_valid3, res_ready3, busy3;
    logic [2:0]       cmd_op3, alu_op3, res_op3;
    logic [WIDTH-1:0] cmd_a3, cmd_b3, alu_a3, alu_b3, alu_result3, res_data3;
    logic [2:0]       fifo_count3;
    logic [15:0]      op_count3;

    assign alu_result3 = alu_a3 + alu_b3 + tick[15:0];

    alu_issue_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ALU_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
        .cmd_op(cmd_op3), .cmd_a(cmd_a3), .cmd_b(cmd_b3),
        .alu_op(alu_op3), .alu_a(alu_a3), .alu_b(alu_b3), .alu_result(alu_result3),
        .res_valid(res_valid3), .res_ready(res_ready3),
        .res_data(res_data3), .res_op(res_op3),
        .busy(busy3), .fifo_count(fifo_count3), .op_count(op_count3)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [15:0] data;
        logic [2:0]  op;
    } exp_t;

    typedef struct {
        logic [15:0] data;
        logic [2:0]  op;
        logic [31:0] at_tick;
    } exp3_t;

    exp_t        exp_q[$];
    exp3_t       exp3_q[$];
    logic [15:0] model_ops = 16'd0;

    // Scoreboard for instance A: handshakes are decided at the negedge sample.
    always @(negedge clk) begin
        if (rst_n) begin
            exp_t e;
            check("op_count", op_count, model_ops);
            if (cmd_valid && cmd_ready)
                exp_q.push_back('{data: 16'(cmd_a + cmd_b), op: cmd_op});
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("res_data", res_data, e.data);
                    check("res_op", res_op, e.op);
                end
                model_ops = model_ops + 16'd1;
            end
        end
    end

    // Monitor for instance B: res_ready3 is held high so each result shows once.
    always @(negedge clk) begin
        if (rst_n && res_valid3) begin
            exp3_t e;
            if (exp3_q.size() == 0) begin
                check("unexpected_result3", 1, 0);
            end else begin
                e = exp3_q.pop_front();
                check("res_data3", res_data3, e.data);
                check("res_op3", res_op3, e.op);
                check("res_time3", tick, e.at_tick);
            end
        end
    end

    task automatic push(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        bit accepted = 0;
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_a = a;
        cmd_b = b;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                accepted = 1;
                break;
            end
        end
        if (!accepted) check("push_timeout", 0, 1);
        @(posedge clk) #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) break;
        end
        check("drain_queue", exp_q.size(), 0);
        check("drain_busy", busy, 0);
        @(posedge clk) #1;
    endtask

    // Isolated op on instance B: capture must see the ALU value present before
    // the 3rd edge after alu_* load, i.e. 4 edges after acceptance.
    task automatic iso_op3(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] t;
        cmd_valid3 = 1'b1;
        cmd_op3 = op;
        cmd_a3 = a;
        cmd_b3 = b;
        @(negedge clk);
        check("cmd_ready3", cmd_ready3, 1);
        @(posedge clk) #1;
        t = tick;
        cmd_valid3 = 1'b0;
        exp3_q.push_back('{data: 16'(a + b + 16'(t + 32'd3)), op: op, at_tick: t + 32'd4});
        repeat (8) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ops_before;
        rst_n = 1'b0;
        cmd_valid = 0; cmd_op = 0; cmd_a = 0; cmd_b = 0; res_ready = 0;
        cmd_valid3 = 0; cmd_op3 = 0; cmd_a3 = 0; cmd_b3 = 0; res_ready3 = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_res_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_op_count", op_count, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_res_data", res_data, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
        check("rst_cmd_ready", cmd_ready, 1);

        // Basic latency: accept at N, alu_* after N+1, result after N+2, count after N+3
        res_ready = 1'b1;
        cmd_valid = 1'b1; cmd_op = 3'b000; cmd_a = 16'h0003; cmd_b = 16'h0004;
        @(posedge clk) #1;
        cmd_valid = 1'b0;
        check("t1_fifo_count", fifo_count, 1);
        @(posedge clk) #1;
        check("t1_alu_op", alu_op, 0);
        check("t1_alu_a", alu_a, 16'h0003);
        check("t1_alu_b", alu_b, 16'h0004);
        check("t1_res_valid_early", res_valid, 0);
        @(posedge clk) #1;
        check("t1_res_valid", res_valid, 1);
        check("t1_res_data", res_data, 16'h0007);
        check("t1_res_op", res_op, 0);
        @(posedge clk) #1;
        check("t1_op_count", op_count, 1);
        check("t1_res_valid_clr", res_valid, 0);
        drain();

        // Back-to-back fill with consumer stalled: 1 in OUT, 4 queued
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(3'(i), 16'(i), 16'd1);
        cmd_valid = 1'b0;
        check("t2_fifo_count", fifo_count, 4);
        check("t2_cmd_ready", cmd_ready, 0);
        check("t2_res_valid", res_valid, 1);
        res_ready = 1'b1;
        drain();

        // Output held stable while stalled, counted once on accept
        res_ready = 1'b0;
        ops_before = model_ops;
        push(3'b110, 16'h1234, 16'h1111);
        cmd_valid = 1'b0;
        for (int i = 0; i < 20 && !res_valid; i++) @(negedge clk);
        check("t3_res_seen", res_valid, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t3_hold_valid", res_valid, 1);
            check("t3_hold_data", res_data, 16'h2345);
            check("t3_hold_op", res_op, 3'b110);
        end
        @(posedge clk) #1;
        res_ready = 1'b1;
        @(posedge clk) #1;
        check("t3_op_count_once", op_count, 32'(ops_before) + 1);
        drain();

        // Randomized traffic with random back-pressure
        for (int c = 0; c < 1500; c++) begin
            cmd_valid = ($urandom_range(0, 9) < 6);
            cmd_op    = 3'($urandom_range(0, 7));
            cmd_a     = 16'($urandom);
            cmd_b     = 16'($urandom);
            res_ready = ($urandom_range(0, 9) < 5);
            @(posedge clk) #1;
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        drain();

        // op_count wrap from 0xFFFF
        force dut.op_count_q = 16'hFFFF;
        model_ops = 16'hFFFF;
        #2 release dut.op_count_q;
        @(posedge clk) #1;
        push(3'b011, 16'h00FF, 16'h0F00);
        cmd_valid = 1'b0;
        drain();
        check("wrap_op_count", op_count, 16'h0000);

        // Longer latency with a drifting ALU output
        for (int i = 0; i < 6; i++)
            iso_op3(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));

        // Asynchronous reset mid-EXEC with two commands queued
        cmd_valid3 = 1'b1; cmd_op3 = 3'd1; cmd_a3 = 16'h1111; cmd_b3 = 16'h2222;
        @(posedge clk) #1;
        cmd_op3 = 3'd2; cmd_a3 = 16'h3333;
        @(posedge clk) #1;
        cmd_op3 = 3'd3; cmd_a3 = 16'h4444;
        @(posedge clk) #1;
        cmd_valid3 = 1'b0;
        check("t5_fifo_count_pre", fifo_count3, 2);
        check("t5_busy_pre", busy3, 1);
        check("t5_alu_a_pre", alu_a3, 16'h1111);
        #2 rst_n = 1'b0;
        exp_q.delete();
        exp3_q.delete();
        model_ops = 16'd0;
        #1;
        check("t5_alu_op", alu_op3, 0);
        check("t5_alu_a", alu_a3, 0);
        check("t5_alu_b", alu_b3, 0);
        check("t5_res_valid", res_valid3, 0);
        check("t5_res_data", res_data3, 0);
        check("t5_res_op", res_op3, 0);
        check("t5_busy", busy3, 0);
        check("t5_fifo_count", fifo_count3, 0);
        check("t5_op_count", op_count3, 0);
        check("t5_op_count_a", op_count, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1;
        check("t5_cmd_ready", cmd_ready3, 1);
        repeat (20) @(posedge clk);
        #1;
        check("t5_no_stale", res_valid3, 0);
        check("t5_idle", busy3, 0);
        iso_op3(3'd7, 16'hABCD, 16'h0101);
        check("t5_op_count_after", op_count3, 1);
        check("final_queue3", exp3_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
